// File: rtl/tmu2_fmlarb.sv
// Three-port burst arbiter for the TMU2 FML master: destination read (0),
// texel read (1) and pixel write-back (2) share one FML port, one 4-beat burst at a time.
module tmu2_fmlarb #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    output logic                 m0_ack,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    output logic                 m1_ack,

    input  logic [fml_depth-1:0] m2_adr,
    input  logic                 m2_stb,
    output logic                 m2_ack,
    input  logic [63:0]          m2_do,
    input  logic [7:0]           m2_sel,

    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [63:0]          fml_do,
    output logic [7:0]           fml_sel,

    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [1:0] r_rr;
    logic [1:0] w_rr_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    logic [2:0] w_req;
    logic [1:0] w_pick;
    logic       w_active;
    logic       w_wr_mux;

    assign w_req = {m2_stb, m1_stb, m0_stb};

    // Round-robin: the port after the last winner is searched first.
    always_comb begin
        w_pick = r_rr;
        case (r_rr)
            2'd0: begin
                if (w_req[1])      w_pick = 2'd1;
                else if (w_req[2]) w_pick = 2'd2;
                else if (w_req[0]) w_pick = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_pick = 2'd2;
                else if (w_req[0]) w_pick = 2'd0;
                else if (w_req[1]) w_pick = 2'd1;
            end
            default: begin
                if (w_req[0])      w_pick = 2'd0;
                else if (w_req[1]) w_pick = 2'd1;
                else if (w_req[2]) w_pick = 2'd2;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_grant <= 2'd0;
            r_rr    <= 2'd0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rr    <= w_rr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_pick;
                    w_rr_nxt    = w_pick;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (fml_ack) begin
                    w_cnt_nxt   = 2'd1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_active = (r_state == S_REQ) || (r_state == S_BURST);
    assign w_wr_mux = w_active && (r_grant == 2'd2);

    // The ack cycle is the first data beat, so acks are only meaningful in REQ.
    always_comb begin
        fml_stb = (r_state == S_REQ);
        fml_we  = 1'b0;
        fml_adr = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        m2_ack  = 1'b0;
        if (r_state == S_REQ) begin
            fml_we = (r_grant == 2'd2);
            case (r_grant)
                2'd0:    fml_adr = m0_adr;
                2'd1:    fml_adr = m1_adr;
                2'd2:    fml_adr = m2_adr;
                default: fml_adr = '0;
            endcase
            m0_ack = fml_ack && (r_grant == 2'd0);
            m1_ack = fml_ack && (r_grant == 2'd1);
            m2_ack = fml_ack && (r_grant == 2'd2);
        end
    end

    always_comb begin
        fml_do  = 64'd0;
        fml_sel = 8'd0;
        if (w_wr_mux) begin
            fml_do  = m2_do;
            fml_sel = m2_sel;
        end
    end

    assign busy = (r_state != S_IDLE) || m0_stb || m1_stb || m2_stb;

endmodule
